// File: rtl/cache_mem_ctrl_if.sv
// Bus bundle between the access sequencer and its environment: CPU data port,
// cache lookup/fill port and backing-memory req/ack port.
interface cache_mem_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
);

  // CPU side
  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_done;

  // Cache side
  logic                  c_we;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0] c_wdata;
  logic [DATA_WIDTH-1:0] c_rdata;
  logic                  c_hit;

  // Memory side
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  // Sequencer view
  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_done,
    output c_we, c_addr, c_wdata,
    input  c_rdata, c_hit,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  // Environment view (CPU, cache and memory models)
  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_done,
    input  c_we, c_addr, c_wdata,
    output c_rdata, c_hit,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/cache_mem_ctrl.sv
// Single-outstanding access sequencer between the CPU data port and a small
// LRU data cache. Reads look up the cache and fetch from memory on a miss;
// writes go through to memory first and then update the cache line.
// Saturating hit/miss counters track read outcomes for debug.
module cache_mem_ctrl #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  cache_mem_ctrl_if.master     bus_io,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] hit_cnt_o,
  output logic [CNT_WIDTH-1:0] miss_cnt_o
);

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StMemRd,
    StMemWr,
    StFill
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  done_q, done_d;
  logic [CNT_WIDTH-1:0]  hit_q, hit_d;
  logic [CNT_WIDTH-1:0]  miss_q, miss_d;

  // Next-state, latch and counter update logic
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    hit_d   = hit_q;
    miss_d  = miss_q;

    unique case (state_q)
      StIdle: begin
        if (bus_io.cpu_req) begin
          addr_d  = bus_io.cpu_addr;
          we_d    = bus_io.cpu_we;
          wdata_d = bus_io.cpu_wdata;
          state_d = bus_io.cpu_we ? StMemWr : StLookup;
        end
      end
      StLookup: begin
        if (bus_io.c_hit) begin
          rdata_d = bus_io.c_rdata;
          done_d  = 1'b1;
          if (hit_q != '1) begin
            hit_d = hit_q + 1'b1;
          end
          state_d = StIdle;
        end else begin
          if (miss_q != '1) begin
            miss_d = miss_q + 1'b1;
          end
          state_d = StMemRd;
        end
      end
      StMemRd: begin
        if (bus_io.mem_ack) begin
          data_d  = bus_io.mem_rdata;
          state_d = StFill;
        end
      end
      StMemWr: begin
        if (bus_io.mem_ack) begin
          data_d  = wdata_q;
          state_d = StFill;
        end
      end
      StFill: begin
        done_d = 1'b1;
        // Writes leave the last read value visible on cpu_rdata
        if (!we_q) begin
          rdata_d = data_q;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  // Control strobes decode straight from the state register
  always_comb begin
    busy_o           = (state_q != StIdle);
    bus_io.mem_req   = (state_q == StMemRd) || (state_q == StMemWr);
    bus_io.mem_we    = (state_q == StMemWr);
    bus_io.c_we      = (state_q == StFill);
    // Cache and memory share the latched address so lookups stay stable
    bus_io.c_addr    = addr_q;
    bus_io.mem_addr  = addr_q;
    bus_io.c_wdata   = data_q;
    bus_io.mem_wdata = wdata_q;
    bus_io.cpu_rdata = rdata_q;
    bus_io.cpu_done  = done_q;
    hit_cnt_o        = hit_q;
    miss_cnt_o       = miss_q;
  end

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Scoreboard bench for cache_mem_ctrl: a 4-entry LRU cache model and a memory
// model with programmable ack delay surround the DUT; directed accesses push
// expected completions, memory requests and cache fills into queues that a
// negedge monitor pops and compares.
module tb_cache_mem_ctrl;

  localparam int unsigned CntW = 2;

  typedef struct packed {
    logic [7:0]  rdata;
    logic [31:0] cyc;
  } done_exp_t;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } mem_exp_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } fill_exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            busy;
  logic [CntW-1:0] hit_cnt;
  logic [CntW-1:0] miss_cnt;

  cache_mem_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

  cache_mem_ctrl #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(8),
    .CNT_WIDTH (CntW)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus_io    (bus),
    .busy_o    (busy),
    .hit_cnt_o (hit_cnt),
    .miss_cnt_o(miss_cnt)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int done_seen = 0;

  done_exp_t done_q[$];
  mem_exp_t  mem_q[$];
  fill_exp_t fill_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // ---------------- cache model: 4 entries, true LRU by timestamp ----------------
  logic        cache_clr;
  logic [7:0]  ct_tag[4];
  logic [7:0]  ct_data[4];
  logic        ct_vld[4];
  int unsigned ct_stamp[4];
  int unsigned stamp_q = 0;
  logic        m_hit;
  logic [7:0]  m_rdata;
  int          hidx;
  int          victim;
  logic        lookup;

  always_comb begin
    m_hit   = 1'b0;
    m_rdata = 8'h00;
    hidx    = 0;
    for (int i = 0; i < 4; i++) begin
      if (ct_vld[i] && ct_tag[i] == bus.c_addr) begin
        m_hit   = 1'b1;
        m_rdata = ct_data[i];
        hidx    = i;
      end
    end
  end

  always_comb begin
    logic found;
    found  = 1'b0;
    victim = 0;
    for (int i = 0; i < 4; i++) begin
      if (!ct_vld[i] && !found) begin
        victim = i;
        found  = 1'b1;
      end
    end
    if (!found) begin
      for (int i = 0; i < 4; i++) begin
        if (ct_stamp[i] < ct_stamp[victim]) victim = i;
      end
    end
  end

  assign bus.c_hit   = m_hit;
  assign bus.c_rdata = m_rdata;
  // The DUT is in its lookup state when busy without a memory or fill strobe
  assign lookup = busy && !bus.mem_req && !bus.c_we;

  always @(posedge clk) begin
    stamp_q <= stamp_q + 1;
    if (cache_clr) begin
      for (int i = 0; i < 4; i++) begin
        ct_vld[i]   <= 1'b0;
        ct_stamp[i] <= 0;
        ct_tag[i]   <= 8'h00;
        ct_data[i]  <= 8'h00;
      end
    end else if (bus.c_we) begin
      if (m_hit) begin
        ct_data[hidx]  <= bus.c_wdata;
        ct_stamp[hidx] <= stamp_q;
      end else begin
        ct_vld[victim]   <= 1'b1;
        ct_tag[victim]   <= bus.c_addr;
        ct_data[victim]  <= bus.c_wdata;
        ct_stamp[victim] <= stamp_q;
      end
    end else if (lookup && m_hit) begin
      ct_stamp[hidx] <= stamp_q;
    end
  end

  // ---------------- memory model: ack after mem_wait extra cycles ----------------
  logic       mem_ack_m;
  logic       ack_inject;
  int         mem_wait;
  assign bus.mem_ack = mem_ack_m | ack_inject;

  initial begin
    logic [7:0] mem [256];
    int wcnt;
    wcnt          = 0;
    mem_ack_m     = 1'b0;
    bus.mem_rdata = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'h10] = 8'hA5;
    forever begin
      @(posedge clk);
      #1;
      mem_ack_m = 1'b0;
      if (bus.mem_req) begin
        if (wcnt >= mem_wait) begin
          mem_ack_m = 1'b1;
          if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
          else bus.mem_rdata = mem[bus.mem_addr];
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // ---------------- monitor: pops scoreboard queues on DUT activity ----------------
  logic req_prev = 1'b0;
  initial begin
    done_exp_t de;
    mem_exp_t  me;
    fill_exp_t fe;
    forever begin
      @(negedge clk);
      if (bus.cpu_done) begin
        done_seen++;
        if (done_q.size() == 0) begin
          fail("unexpected_cpu_done");
        end else begin
          de = done_q.pop_front();
          check("cpu_rdata", 32'(bus.cpu_rdata), 32'(de.rdata));
          check("done_cycle", cyc, de.cyc);
        end
      end
      if (bus.mem_req && !req_prev) begin
        if (mem_q.size() == 0) begin
          fail("unexpected_mem_req");
        end else begin
          me = mem_q.pop_front();
          check("mem_we", 32'(bus.mem_we), 32'(me.we));
          check("mem_addr", 32'(bus.mem_addr), 32'(me.addr));
          if (me.we) check("mem_wdata", 32'(bus.mem_wdata), 32'(me.wdata));
        end
      end
      req_prev = bus.mem_req;
      if (bus.c_we) begin
        if (fill_q.size() == 0) begin
          fail("unexpected_c_we");
        end else begin
          fe = fill_q.pop_front();
          check("c_addr", 32'(bus.c_addr), 32'(fe.addr));
          check("c_wdata", 32'(bus.c_wdata), 32'(fe.data));
        end
      end
    end
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic wait_done(input int target, input string name);
    int n;
    n = 0;
    while (done_seen < target && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (done_seen < target) fail({name, "_timeout"});
  endtask

  task automatic issue(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b0;
  endtask

  // lat counts cycles from the cycle cpu_req is high to the cycle cpu_done is high
  task automatic do_read(input logic [7:0] addr, input logic [7:0] exp, input int lat,
                         input logic miss, input string name);
    int tgt;
    tgt = done_seen + 1;
    if (miss) begin
      mem_q.push_back('{we: 1'b0, addr: addr, wdata: 8'h00});
      fill_q.push_back('{addr: addr, data: exp});
    end
    done_q.push_back('{rdata: exp, cyc: cyc + lat});
    issue(1'b0, addr, 8'h00);
    wait_done(tgt, name);
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [7:0] data,
                          input logic [7:0] rd_keep, input int lat, input string name);
    int tgt;
    tgt = done_seen + 1;
    mem_q.push_back('{we: 1'b1, addr: addr, wdata: data});
    fill_q.push_back('{addr: addr, data: data});
    done_q.push_back('{rdata: rd_keep, cyc: cyc + lat});
    issue(1'b1, addr, data);
    wait_done(tgt, name);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int tgt;
    rst           = 1'b1;
    cache_clr     = 1'b1;
    ack_inject    = 1'b0;
    mem_wait      = 0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 8'h00;
    bus.cpu_wdata = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    cache_clr = 1'b0;

    // Reset state
    check("rst_cpu_done", 32'(bus.cpu_done), 0);
    check("rst_cpu_rdata", 32'(bus.cpu_rdata), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_mem_req", 32'(bus.mem_req), 0);
    check("rst_c_we", 32'(bus.c_we), 0);
    check("rst_hit_cnt", 32'(hit_cnt), 0);
    check("rst_miss_cnt", 32'(miss_cnt), 0);

    // Cold read miss: ack on third mem_req cycle -> 1 lookup + 3 mem + fill + done
    mem_wait = 2;
    do_read(8'h10, 8'hA5, 6, 1'b1, "t1_read_miss");
    check("t1_miss_cnt", 32'(miss_cnt), 1);
    check("t1_hit_cnt", 32'(hit_cnt), 0);

    // Repeat read hits with no memory traffic
    do_read(8'h10, 8'hA5, 2, 1'b0, "t2_read_hit");
    check("t2_hit_cnt", 32'(hit_cnt), 1);

    // Write-through, then read back from cache; write keeps cpu_rdata at 0xA5
    mem_wait = 1;
    do_write(8'h20, 8'h3C, 8'hA5, 4, "t3_write");
    do_read(8'h20, 8'h3C, 2, 1'b0, "t3_read_hit");
    check("t3_hit_cnt", 32'(hit_cnt), 2);
    check("t3_miss_cnt", 32'(miss_cnt), 1);

    // Reset while waiting in MEM_RD, then a stray ack
    mem_wait = 1000;
    mem_q.push_back('{we: 1'b0, addr: 8'h55, wdata: 8'h00});
    issue(1'b0, 8'h55, 8'h00);
    for (int n = 0; n < 20 && !bus.mem_req; n++) begin
      @(posedge clk);
      #1;
    end
    check("t5_mem_req_seen", 32'(bus.mem_req), 1);
    @(posedge clk);
    #1;
    do_reset();
    check("t5_mem_req_drop", 32'(bus.mem_req), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_cpu_rdata", 32'(bus.cpu_rdata), 0);
    check("t5_hit_cnt", 32'(hit_cnt), 0);
    check("t5_miss_cnt", 32'(miss_cnt), 0);
    ack_inject = 1'b1;
    @(posedge clk);
    #1;
    ack_inject = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t5_busy_after_ack", 32'(busy), 0);
    check("t5_cpu_done", 32'(bus.cpu_done), 0);
    check("t5_miss_after_ack", 32'(miss_cnt), 0);

    // Eviction: cache holds 0x10 (older) and 0x20; three write-misses fill it and evict 0x10
    mem_wait = 0;
    do_write(8'h40, 8'h01, 8'h00, 3, "t4_write40");
    do_write(8'h41, 8'h02, 8'h00, 3, "t4_write41");
    do_write(8'h42, 8'h03, 8'h00, 3, "t4_write42");
    do_read(8'h10, 8'hA5, 4, 1'b1, "t4_read_evicted");
    check("t4_miss_cnt", 32'(miss_cnt), 1);
    do_read(8'h42, 8'h03, 2, 1'b0, "t4_read_hit42");
    check("t4_hit_cnt", 32'(hit_cnt), 1);

    // Held cpu_req: one access per IDLE sample; five hits saturate a 2-bit counter
    do_reset();
    check("t6_hit_cnt_clr", 32'(hit_cnt), 0);
    tgt = done_seen + 5;
    for (int i = 1; i <= 5; i++) done_q.push_back('{rdata: 8'hA5, cyc: cyc + 2 * i});
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 8'h10;
    repeat (9) @(posedge clk);
    #1;
    bus.cpu_req = 1'b0;
    wait_done(tgt, "t6_held_req");
    repeat (4) @(posedge clk);
    #1;
    check("t6_hit_cnt_sat", 32'(hit_cnt), 3);
    check("t6_miss_cnt", 32'(miss_cnt), 0);
    check("t6_busy", 32'(busy), 0);

    // All expectations consumed
    check("done_q_left", done_q.size(), 0);
    check("mem_q_left", mem_q.size(), 0);
    check("fill_q_left", fill_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
